camera_blob_writer: RTL

Host-side writer for the camera/physics shared memory. Accepts per-frame blob coordinates from the camera pipeline, buffers them, and writes them as a blob table into the shared memory through its host write port (camera_addr / camera_dout / camera_mwe). The physics beta reads the table through the client port. A header word is committed last, so a changed sequence number tells the beta that a complete frame is available.

---
 rtl/camera_blob_writer_if.sv | 25 ++
 rtl/camera_blob_writer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/camera_blob_writer_if.sv
// Blob stream from the camera pipeline plus the shared-memory host write port.
// The writer sits on the slave side; the camera pipeline/host sits on the master side.
interface camera_blob_writer_if;
    logic        frame_start;
    logic        frame_end;
    logic        blob_valid;
    logic [9:0]  blob_x;
    logic [9:0]  blob_y;
    logic        blob_ready;
    logic [31:0] camera_addr;
    logic [31:0] camera_dout;
    logic        camera_mwe;
    logic        busy;
    logic [14:0] frame_seq;

    modport master (
        output frame_start, frame_end, blob_valid, blob_x, blob_y,
        input  blob_ready, camera_addr, camera_dout, camera_mwe, busy, frame_seq
    );

    modport slave (
        input  frame_start, frame_end, blob_valid, blob_x, blob_y,
        output blob_ready, camera_addr, camera_dout, camera_mwe, busy, frame_seq
    );
endinterface

// File: rtl/camera_blob_writer.sv
// Buffers per-frame blob coordinates and writes them as a table into the
// camera/physics shared memory. The header word (ovf, seq, count) is written
// last so a changed sequence number marks a complete frame for the reader.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no frame open; blobs accepted and discarded
// ST_ACTIVE | frame open; blobs buffered and written as table entries
// ST_DRAIN  | frame ended; flushing buffered blobs, input stalled
// ST_HEADER | one cycle; header word written, sequence number advanced
module camera_blob_writer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned MAX_BLOBS  = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    camera_blob_writer_if.slave  bus
);

    localparam int unsigned     PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  FULL_OCC = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [7:0]      MAX_CNT  = 8'(MAX_BLOBS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HEADER = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [14:0]        seq_q, seq_d;
    logic               pend_q, pend_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     occ_q, occ_d;
    logic [19:0]        fifo_q [FIFO_DEPTH];
    logic [19:0]        fifo_d [FIFO_DEPTH];
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        dout_q, dout_d;
    logic               mwe_q, mwe_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               flush;
    logic [19:0]        rd_data;

    assign fifo_full  = (occ_q == FULL_OCC);
    assign fifo_empty = (occ_q == '0);
    assign rd_data    = fifo_q[rd_ptr_q];

    assign bus.camera_addr = addr_q;
    assign bus.camera_dout = dout_q;
    assign bus.camera_mwe  = mwe_q;
    assign bus.busy        = (state_q == ST_DRAIN) || (state_q == ST_HEADER);
    assign bus.frame_seq   = seq_q;

    // Ready depends only on state and FIFO-full; held low while reset is asserted.
    always_comb begin
        bus.blob_ready = 1'b0;
        if (reset) begin
            case (state_q)
                ST_IDLE:   bus.blob_ready = 1'b1;
                ST_ACTIVE: bus.blob_ready = !fifo_full;
                default:   bus.blob_ready = 1'b0;
            endcase
        end
    end

    // Next-state, FIFO control and registered write-port generation.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        seq_d    = seq_q;
        pend_d   = pend_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        fifo_d   = fifo_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        mwe_d    = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        flush    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.frame_start || pend_q) begin
                    state_d = ST_ACTIVE;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    pend_d  = 1'b0;
                end
            end
            ST_ACTIVE: begin
                push = bus.blob_valid && !fifo_full;
                if (bus.frame_end) begin
                    // frame_end wins over a coincident frame_start; the start is deferred
                    state_d = ST_DRAIN;
                    if (bus.frame_start) pend_d = 1'b1;
                end else if (bus.frame_start) begin
                    flush   = 1'b1;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
                pop = !fifo_empty && !flush;
            end
            ST_DRAIN: begin
                if (bus.frame_start) pend_d = 1'b1;
                pop = !fifo_empty;
                if (fifo_empty) state_d = ST_HEADER;
            end
            ST_HEADER: begin
                mwe_d  = 1'b1;
                addr_d = BASE_ADDR;
                dout_d = {ovf_q, seq_q + 15'd1, 8'h00, count_q};
                seq_d  = seq_q + 15'd1;
                if (pend_q || bus.frame_start) begin
                    state_d = ST_ACTIVE;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    pend_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            if (count_q < MAX_CNT) begin
                mwe_d   = 1'b1;
                addr_d  = BASE_ADDR + ((32'(count_q) + 32'd1) << 2);
                dout_d  = {6'b0, rd_data[19:10], 6'b0, rd_data[9:0]};
                count_d = count_q + 8'd1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = {bus.blob_y, bus.blob_x};
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            occ_d = occ_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        end
    end

    // State, counters, FIFO storage and write-port registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            seq_q    <= '0;
            pend_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            addr_q   <= '0;
            dout_q   <= '0;
            mwe_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            seq_q    <= seq_d;
            pend_q   <= pend_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            fifo_q   <= fifo_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            mwe_q    <= mwe_d;
        end
    end

endmodule
